// File: rtl/dmem_arbiter_rv32i_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_rv32i_if
// Bundle of every signal between the data-memory arbiter and its neighbours.
//   p0_*  : core load/store unit request/response port
//   p1_*  : debug/loader request/response port
//   mem_* : data-memory side (store enable, size, address, data, read word)
// Modports:
//   slave  : arbiter view (takes requests and memory read data, drives
//            grants, responses and the memory command)
//   master : environment view (requesters plus memory), the mirror image
// -----------------------------------------------------------------------------
interface dmem_arbiter_rv32i_if;
   // port 0 command / response
   logic        p0_req;
   logic        p0_we;
   logic [1:0]  p0_size;
   logic        p0_unsigned;
   logic [31:0] p0_addr;
   logic [31:0] p0_wdata;
   logic        p0_gnt;
   logic        p0_rvalid;
   logic [31:0] p0_rdata;
   logic        p0_err;
   // port 1 command / response
   logic        p1_req;
   logic        p1_we;
   logic [1:0]  p1_size;
   logic        p1_unsigned;
   logic [31:0] p1_addr;
   logic [31:0] p1_wdata;
   logic        p1_gnt;
   logic        p1_rvalid;
   logic [31:0] p1_rdata;
   logic        p1_err;
   // memory side
   logic        mem_store;
   logic [1:0]  mem_storetype;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  p0_req, p0_we, p0_size, p0_unsigned, p0_addr, p0_wdata,
      output p0_gnt, p0_rvalid, p0_rdata, p0_err,
      input  p1_req, p1_we, p1_size, p1_unsigned, p1_addr, p1_wdata,
      output p1_gnt, p1_rvalid, p1_rdata, p1_err,
      output mem_store, mem_storetype, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output p0_req, p0_we, p0_size, p0_unsigned, p0_addr, p0_wdata,
      input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
      output p1_req, p1_we, p1_size, p1_unsigned, p1_addr, p1_wdata,
      input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
      input  mem_store, mem_storetype, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter_rv32i.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_rv32i
// Two-port round-robin arbiter and fixed 4-cycle access sequencer for the
// RV32I data memory (synchronous 1-cycle read, lane-aligning byte writes).
// Every access runs IDLE -> ISSUE -> WAIT -> RESP; illegal accesses take the
// same path but never write memory and return zero data with err set.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : dmem_arbiter_rv32i_if.slave (p0/p1 request ports + memory side)
// Parameter:
//   DEPTH_BYTES : memory size; addresses at or above it are errors
// -----------------------------------------------------------------------------
module dmem_arbiter_rv32i #(
   parameter int DEPTH_BYTES = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   dmem_arbiter_rv32i_if.slave        bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_BYTES);

   // Illegal size, misalignment, or out of range.
   function automatic logic access_err(input logic [1:0]  size,
                                       input logic [31:0] addr);
      logic bad;
      bad = (size == 2'b11)
         || ((size == 2'b01) && addr[0])
         || ((size == 2'b10) && (addr[1:0] != 2'b00))
         || (addr >= DEPTH_LIM);
      return bad;
   endfunction

   // Pick the addressed lane(s) out of the memory word and extend to 32 bits.
   function automatic logic [31:0] load_ext(input logic [31:0] word,
                                            input logic [1:0]  size,
                                            input logic [1:0]  lane,
                                            input logic        uns);
      logic        [7:0]  b;
      logic        [15:0] h;
      logic        [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   r = {{24{b[7] & ~uns}}, b};
         2'b01:   r = {{16{h[15] & ~uns}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // state and captured command
   state_t      state_q;
   logic        last_q;
   logic        win_q;
   logic        we_q;
   logic        uns_q;
   logic        err_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   // registered responses, one bit per port
   logic [1:0]  gnt_q;
   logic [1:0]  rvalid_q;
   logic [1:0]  rerr_q;
   logic [31:0] rdata0_q;
   logic [31:0] rdata1_q;

   // capture candidates
   logic        any_req_d;
   logic        win_d;
   logic        we_d;
   logic        uns_d;
   logic        err_d;
   logic [1:0]  size_d;
   logic [31:0] addr_d;
   logic [31:0] wdata_d;
   logic [31:0] resp_d;

   always_comb begin
      any_req_d = bus.p0_req | bus.p1_req;
      // On a tie the port that was not served last wins; otherwise the
      // only requester wins (p1 iff p1 alone is requesting).
      win_d = (bus.p0_req & bus.p1_req) ? ~last_q : bus.p1_req;
      if (win_d) begin
         we_d    = bus.p1_we;
         size_d  = bus.p1_size;
         uns_d   = bus.p1_unsigned;
         addr_d  = bus.p1_addr;
         wdata_d = bus.p1_wdata;
      end else begin
         we_d    = bus.p0_we;
         size_d  = bus.p0_size;
         uns_d   = bus.p0_unsigned;
         addr_d  = bus.p0_addr;
         wdata_d = bus.p0_wdata;
      end
      err_d  = access_err(size_d, addr_d);
      // Stores and rejected accesses answer with zero data.
      resp_d = (we_q | err_q) ? 32'd0
                              : load_ext(bus.mem_rdata, size_q, addr_q[1:0], uns_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         win_q    <= 1'b0;
         we_q     <= 1'b0;
         uns_q    <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         gnt_q    <= 2'b00;
         rvalid_q <= 2'b00;
         rerr_q   <= 2'b00;
         rdata0_q <= 32'd0;
         rdata1_q <= 32'd0;
      end else begin
         // Pulse outputs default low; the captured command is left alone so
         // the memory-side outputs keep their last value through IDLE.
         gnt_q    <= 2'b00;
         rvalid_q <= 2'b00;
         rerr_q   <= 2'b00;
         rdata0_q <= 32'd0;
         rdata1_q <= 32'd0;
         case (state_q)
            IDLE: begin
               if (any_req_d) begin
                  state_q <= ISSUE;
                  win_q   <= win_d;
                  we_q    <= we_d;
                  size_q  <= size_d;
                  uns_q   <= uns_d;
                  addr_q  <= addr_d;
                  wdata_q <= wdata_d;
                  err_q   <= err_d;
                  gnt_q   <= win_d ? 2'b10 : 2'b01;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               // mem_rdata is valid now; latch the extended response.
               state_q  <= RESP;
               rvalid_q <= win_q ? 2'b10 : 2'b01;
               rerr_q   <= win_q ? {err_q, 1'b0} : {1'b0, err_q};
               if (win_q) begin
                  rdata1_q <= resp_d;
               end else begin
                  rdata0_q <= resp_d;
               end
            end
            RESP: begin
               state_q <= IDLE;
               last_q  <= win_q;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Write strobe is combinational so a reset arriving during ISSUE kills
   // the write in that same cycle.
   assign bus.mem_store     = (state_q == ISSUE) & we_q & ~err_q & ~rst;
   assign bus.mem_storetype = size_q;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_wdata     = wdata_q;

   assign bus.p0_gnt    = gnt_q[0];
   assign bus.p1_gnt    = gnt_q[1];
   assign bus.p0_rvalid = rvalid_q[0];
   assign bus.p1_rvalid = rvalid_q[1];
   assign bus.p0_err    = rerr_q[0];
   assign bus.p1_err    = rerr_q[1];
   assign bus.p0_rdata  = rdata0_q;
   assign bus.p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter_rv32i.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter_rv32i
// Bench for dmem_arbiter_rv32i: a lane-aligning 1-cycle-read memory sits on
// the memory side; a byte-addressed reference memory predicts load results,
// errors and timing for directed and random accesses.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter_rv32i;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_arbiter_rv32i_if bus();

   dmem_arbiter_rv32i #(.DEPTH_BYTES(1024)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int store_cnt = 0;

   // memory attached to the DUT (word array, does its own lane alignment)
   logic [31:0] memw [0:255];
   logic        fill;
   logic [7:0]  fill_idx;
   logic [31:0] fill_val;

   // reference model: plain byte array
   logic [7:0]  ref_mem [0:1023];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] st,
                                         input logic [1:0] lane, input logic [31:0] wd);
      logic [31:0] r;
      r = old;
      case (st)
         2'b00:   r[{lane, 3'b000} +: 8]     = wd[7:0];
         2'b01:   r[{lane[1], 4'b0000} +: 16] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (fill) begin
         memw[fill_idx] <= fill_val;
      end else if (bus.mem_store) begin
         memw[bus.mem_addr[9:2]] <= merge(memw[bus.mem_addr[9:2]], bus.mem_storetype,
                                          bus.mem_addr[1:0], bus.mem_wdata);
      end
      bus.mem_rdata <= memw[bus.mem_addr[9:2]];
   end

   always @(negedge clk) begin
      if (bus.mem_store === 1'b1) store_cnt <= store_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'b11) || (a >= 32'd1024) || ((a % nbytes(sz)) != 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                              input logic uns);
      int unsigned v;
      int n;
      n = nbytes(sz);
      v = 0;
      for (int i = 0; i < n; i++) v = v + (32'(ref_mem[int'(a) + i]) << (8 * i));
      if (!uns && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
      return v;
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      for (int i = 0; i < nbytes(sz); i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * i));
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int port, input logic req, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
      if (port == 0) begin
         bus.p0_req = req; bus.p0_we = we; bus.p0_size = sz;
         bus.p0_unsigned = uns; bus.p0_addr = a; bus.p0_wdata = wd;
      end else begin
         bus.p1_req = req; bus.p1_we = we; bus.p1_size = sz;
         bus.p1_unsigned = uns; bus.p1_addr = a; bus.p1_wdata = wd;
      end
   endtask

   // One complete access from a single port, started at a negedge in IDLE.
   task automatic access(input int port, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd_o);
      logic        e;
      logic [31:0] erd, rd, st_addr, st_wd;
      logic [1:0]  st_type;
      logic        rerr;
      int          s0, gc, rc, other;
      e   = model_err(sz, a);
      erd = (we || e) ? 32'd0 : model_load(sz, a, uns);
      drive(port, 1'b1, we, sz, uns, a, wd);
      s0 = store_cnt; gc = -1; rc = -1; other = 0; rd = 32'd0; rerr = 1'b0;
      st_addr = 32'd0; st_wd = 32'd0; st_type = 2'b00;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if ((port == 0 ? bus.p0_gnt : bus.p1_gnt) === 1'b1) begin
            if (gc < 0) gc = c;
            drive(port, 1'b0, we, sz, uns, a, wd);
         end
         if (c == 1) begin
            st_addr = bus.mem_addr; st_wd = bus.mem_wdata; st_type = bus.mem_storetype;
         end
         if ((port == 0 ? bus.p0_rvalid : bus.p1_rvalid) === 1'b1) begin
            rc = c;
            rd   = (port == 0) ? bus.p0_rdata : bus.p1_rdata;
            rerr = (port == 0) ? bus.p0_err : bus.p1_err;
         end
         if (port == 0 ? (bus.p1_gnt | bus.p1_rvalid | bus.p1_err) !== 1'b0
                       : (bus.p0_gnt | bus.p0_rvalid | bus.p0_err) !== 1'b0) other++;
      end
      drive(port, 1'b0, we, sz, uns, a, wd);
      if (we && !e) model_store(sz, a, wd);
      chk("gnt_cycle", gc, 1);
      chk("rvalid_cycle", rc, 3);
      chk("rdata", rd, erd);
      chk("err", 32'(rerr), 32'(e));
      chk("store_count", store_cnt - s0, (we && !e) ? 1 : 0);
      chk("mem_addr", st_addr, a);
      chk("mem_storetype", 32'(st_type), 32'(sz));
      chk("mem_wdata", st_wd, wd);
      chk("other_port_quiet", other, 0);
      rd_o = rd;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd, a, wd, old;
      logic [1:0]  sz;
      logic        we, uns;
      int          port, s0, quiet;
      int          n_g, n_r;
      int          g_c [0:7];
      int          g_p [0:7];
      int          r_c [0:7];
      int          r_p [0:7];
      logic [31:0] r_d [0:7];
      logic [31:0] exp0, exp1;

      rst = 1'b1;
      fill = 1'b0; fill_idx = 8'd0; fill_val = 32'd0;
      drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

      // load both memories with the same random contents
      for (int w = 0; w < 256; w++) begin
         @(negedge clk);
         fill = 1'b1; fill_idx = 8'(w); fill_val = $urandom;
         for (int i = 0; i < 4; i++) ref_mem[4 * w + i] = 8'(fill_val >> (8 * i));
      end
      @(negedge clk);
      fill = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_p0_gnt", 32'(bus.p0_gnt), 0);
      chk("rst_p1_gnt", 32'(bus.p1_gnt), 0);
      chk("rst_p0_rvalid", 32'(bus.p0_rvalid), 0);
      chk("rst_p1_rvalid", 32'(bus.p1_rvalid), 0);
      chk("rst_p0_err", 32'(bus.p0_err), 0);
      chk("rst_p1_err", 32'(bus.p1_err), 0);
      chk("rst_p0_rdata", bus.p0_rdata, 0);
      chk("rst_p1_rdata", bus.p1_rdata, 0);
      chk("rst_mem_store", 32'(bus.mem_store), 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_mem_storetype", 32'(bus.mem_storetype), 0);
      rst = 1'b0;
      @(negedge clk);

      // directed accesses
      access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
      chk("sw_rdata_zero", rd, 32'h0);
      access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
      chk("lw_after_sw", rd, 32'hDEADBEEF);
      access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, rd);
      access(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd);
      chk("lb_0x13", rd, 32'hFFFFFF80);
      access(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd);
      chk("lbu_0x13", rd, 32'h00000080);
      access(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd);
      chk("lh_0x12", rd, 32'hFFFF80FF);
      access(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd);
      chk("lhu_0x12", rd, 32'h000080FF);
      access(0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, rd);
      access(0, 1'b0, 2'b10, 1'b0, 32'h402, 32'h0, rd);
      chk("lw_0x402_rdata", rd, 32'h0);
      access(1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd);
      access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
      chk("word_intact_after_errs", rd, 32'h80FF7F01);

      // random single-port accesses
      for (int k = 0; k < 40; k++) begin
         port = $urandom_range(0, 1);
         we   = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1));
         sz   = 2'($urandom_range(0, 3));
         a    = 32'($urandom_range(0, 1100));
         wd   = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b01) a[0] = 1'b0;
            else if (sz == 2'b10) a[1:0] = 2'b00;
         end
         access(port, we, sz, uns, a, wd, rd);
      end

      // both ports requesting continuously after a fresh reset
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp0 = model_load(2'b10, 32'h10, 1'b0);
      exp1 = model_load(2'b01, 32'h12, 1'b1);
      drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      drive(1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
      n_g = 0; n_r = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (bus.p0_gnt === 1'b1 && n_g < 8) begin g_c[n_g] = c; g_p[n_g] = 0; n_g++; end
         if (bus.p1_gnt === 1'b1 && n_g < 8) begin g_c[n_g] = c; g_p[n_g] = 1; n_g++; end
         if (bus.p0_rvalid === 1'b1 && n_r < 8) begin
            r_c[n_r] = c; r_p[n_r] = 0; r_d[n_r] = bus.p0_rdata; n_r++;
         end
         if (bus.p1_rvalid === 1'b1 && n_r < 8) begin
            r_c[n_r] = c; r_p[n_r] = 1; r_d[n_r] = bus.p1_rdata; n_r++;
         end
      end
      drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      drive(1, 1'b0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
      chk("rr_grant_count", n_g, 4);
      chk("rr_rvalid_count", n_r, 4);
      for (int k = 0; k < 4; k++) begin
         if (k < n_g) begin
            chk("rr_grant_cycle", g_c[k], 1 + 4 * k);
            chk("rr_grant_owner", g_p[k], k % 2);
         end
         if (k < n_r) begin
            chk("rr_rvalid_cycle", r_c[k], 3 + 4 * k);
            chk("rr_rvalid_owner", r_p[k], k % 2);
            chk("rr_rdata", r_d[k], (k % 2 == 0) ? exp0 : exp1);
         end
      end
      @(negedge clk);
      @(negedge clk);

      // reset arriving during ISSUE of a p1 store
      old = model_load(2'b10, 32'h20, 1'b0);
      drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, ~old);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, ~old);
      s0 = store_cnt;
      @(negedge clk);
      chk("issue_rst_mem_store", 32'(bus.mem_store), 0);
      @(negedge clk);
      rst = 1'b0;
      quiet = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if ((bus.p0_rvalid | bus.p1_rvalid | bus.p0_gnt | bus.p1_gnt) !== 1'b0) quiet++;
      end
      chk("issue_rst_no_response", quiet, 0);
      chk("issue_rst_no_store", store_cnt - s0, 0);
      access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd);
      chk("issue_rst_old_word", rd, old);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
